// File: rtl/sb_timer_pkg.sv
// Shared definitions for the sb_timer peripheral: widths, register offsets,
// CTRL/STATUS bit positions and the packed register layouts.
package sb_timer_pkg;

  localparam int unsigned TMR_DW = 32;
  localparam int unsigned TMR_AW = 32;

  localparam logic [31:0] TMR_BASE = 32'h4000_0000;

  // Register byte offsets inside the 256-byte region
  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_COUNT  = 8'h04;
  localparam logic [7:0] TMR_CMP    = 8'h08;
  localparam logic [7:0] TMR_STATUS = 8'h0C;
  localparam logic [7:0] TMR_PRESC  = 8'h10;

  // CTRL bit indices
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_AR = 1;
  localparam int unsigned CTRL_OS = 2;
  localparam int unsigned CTRL_IE = 3;

  // STATUS bit indices
  localparam int unsigned STAT_MATCH = 0;
  localparam int unsigned STAT_OVF   = 1;

  typedef struct packed {
    logic ie;
    logic os;
    logic ar;
    logic en;
  } ctrl_t;

  typedef struct packed {
    logic ovf;
    logic match;
  } status_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: divides the clock by presc+1 while enabled, pulsing tick once
// per period. Held at zero while disabled or when software reprograms it.
module timer_prescaler #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] presc,
  output logic         tick
);

  logic [W-1:0] pcnt_q;
  logic [W-1:0] pcnt_d;

  assign tick = en & (pcnt_q == presc);

  // Next prescale count: wrap on tick, park at zero when idle or cleared
  always_comb begin
    pcnt_d = pcnt_q + W'(1);
    if (!en || clr || tick) begin
      pcnt_d = '0;
    end
  end

  // Prescale count register
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/sb_timer.sv
// Memory-mapped timer/compare slave: register file, compare/overflow logic,
// zero-latency read mux and a registered level interrupt.
module sb_timer
  import sb_timer_pkg::*;
#(
  parameter int unsigned   DW        = TMR_DW,
  parameter int unsigned   AW        = TMR_AW,
  parameter logic [AW-1:0] BASE_ADDR = AW'(TMR_BASE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_rw,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic [DW-1:0] s_rdata,
  output logic          irq_o
);

  ctrl_t         ctrl_q, ctrl_d;
  status_t       status_q, status_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] cmp_q, cmp_d;
  logic [DW-1:0] presc_q, presc_d;
  logic          irq_q, irq_d;

  logic          hit;
  logic [7:0]    off;
  logic          wr_ctrl, wr_count, wr_cmp, wr_status, wr_presc;
  logic          tick;
  logic          eval;
  logic [DW-1:0] rdata_c;
  logic          unused_addr_lsb;

  // Address decode; byte lanes within a word are ignored
  assign hit             = (s_addr[AW-1:8] == BASE_ADDR[AW-1:8]);
  assign off             = {s_addr[7:2], 2'b00};
  assign unused_addr_lsb = ^s_addr[1:0];

  assign wr_ctrl   = s_rw & hit & (off == TMR_CTRL);
  assign wr_count  = s_rw & hit & (off == TMR_COUNT);
  assign wr_cmp    = s_rw & hit & (off == TMR_CMP);
  assign wr_status = s_rw & hit & (off == TMR_STATUS);
  assign wr_presc  = s_rw & hit & (off == TMR_PRESC);

  timer_prescaler #(
    .W(DW)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_q.en),
    .clr  (wr_ctrl | wr_presc),
    .presc(presc_q),
    .tick (tick)
  );

  // A software COUNT write pre-empts this cycle's compare/overflow evaluation
  assign eval = tick & ~wr_count;

  // Next-state for the register file; flag sets applied after W1C so they win
  always_comb begin
    ctrl_d   = ctrl_q;
    status_d = status_q;
    count_d  = count_q;
    cmp_d    = cmp_q;
    presc_d  = presc_q;
    irq_d    = ctrl_q.ie & (status_q.match | status_q.ovf);

    if (wr_status) begin
      status_d.match = status_q.match & ~s_wdata[STAT_MATCH];
      status_d.ovf   = status_q.ovf & ~s_wdata[STAT_OVF];
    end

    if (eval) begin
      if (count_q == cmp_q) begin
        status_d.match = 1'b1;
        count_d        = ctrl_q.ar ? '0 : count_q + DW'(1);
        if (ctrl_q.os) begin
          ctrl_d.en = 1'b0;
        end
      end else if (count_q == {DW{1'b1}}) begin
        status_d.ovf = 1'b1;
        count_d      = '0;
      end else begin
        count_d = count_q + DW'(1);
      end
    end

    if (wr_ctrl) begin
      ctrl_d = ctrl_t'(s_wdata[3:0]);
    end
    if (wr_count) begin
      count_d = s_wdata;
    end
    if (wr_cmp) begin
      cmp_d = s_wdata;
    end
    if (wr_presc) begin
      presc_d = s_wdata;
    end
  end

  // Register file and interrupt flop
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      status_q <= '0;
      count_q  <= '0;
      cmp_q    <= {DW{1'b1}};
      presc_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; unmapped and out-of-region addresses return 0
  always_comb begin
    rdata_c = '0;
    if (!rst && hit) begin
      case (off)
        TMR_CTRL:   rdata_c = DW'(ctrl_q);
        TMR_COUNT:  rdata_c = count_q;
        TMR_CMP:    rdata_c = cmp_q;
        TMR_STATUS: rdata_c = DW'(status_q);
        TMR_PRESC:  rdata_c = presc_q;
        default:    rdata_c = '0;
      endcase
    end
  end

  assign s_rdata = rdata_c;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_sb_timer.sv
// Scoreboard bench for sb_timer: a cycle-level behavioural model predicts
// s_rdata and irq_o for every bus cycle; a negedge monitor compares.
module tb_sb_timer;
  import sb_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_rw = 1'b0;
  logic [31:0] s_addr = 32'h0;
  logic [31:0] s_wdata = 32'h0;
  logic [31:0] s_rdata;
  logic        irq_o;

  always #5 clk = ~clk;

  sb_timer dut (
    .clk    (clk),
    .rst    (rst),
    .s_rw   (s_rw),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .irq_o  (irq_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (architectural view of the peripheral)
  bit          m_en = 0, m_ar = 0, m_os = 0, m_ie = 0;
  bit          m_match = 0, m_ovf = 0, m_irq = 0;
  logic [31:0] m_count = 0, m_cmp = 32'hFFFF_FFFF, m_presc = 0, m_pcnt = 0;

  function automatic logic [31:0] model_read(input bit r, input logic [31:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (!r && a[31:8] == BASE[31:8]) begin
      case (a[7:2])
        6'd0: v = {28'h0, m_ie, m_os, m_ar, m_en};
        6'd1: v = m_count;
        6'd2: v = m_cmp;
        6'd3: v = {30'h0, m_ovf, m_match};
        6'd4: v = m_presc;
        default: v = 32'h0;
      endcase
    end
    return v;
  endfunction

  // Advance the model by one clock edge given the bus cycle just presented
  task automatic model_step(input bit r, input bit rw, input logic [31:0] a,
                            input logic [31:0] wd);
    bit          wr, tick, set_m, set_o;
    bit          n_en, n_match, n_ovf;
    logic [31:0] n_count, n_pcnt;
    int unsigned idx;
    if (r) begin
      m_en = 0; m_ar = 0; m_os = 0; m_ie = 0;
      m_match = 0; m_ovf = 0; m_irq = 0;
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_presc = 0; m_pcnt = 0;
      return;
    end
    wr      = rw && (a[31:8] == BASE[31:8]);
    idx     = int'(a[7:2]);
    tick    = m_en && (m_pcnt == m_presc);
    n_pcnt  = (!m_en || tick) ? 32'h0 : m_pcnt + 1;
    n_en    = m_en;
    n_count = m_count;
    n_match = m_match;
    n_ovf   = m_ovf;
    set_m   = 0;
    set_o   = 0;
    if (tick && !(wr && idx == 1)) begin
      if (m_count == m_cmp) begin
        set_m   = 1;
        n_count = m_ar ? 32'h0 : m_count + 1;
        if (m_os) n_en = 0;
      end else if (m_count == 32'hFFFF_FFFF) begin
        set_o   = 1;
        n_count = 0;
      end else begin
        n_count = m_count + 1;
      end
    end
    m_irq = m_ie && (m_match || m_ovf);
    if (wr) begin
      case (idx)
        0: begin
          n_en = wd[0]; m_ar = wd[1]; m_os = wd[2]; m_ie = wd[3];
          n_pcnt = 0;
        end
        1: n_count = wd;
        2: m_cmp = wd;
        3: begin
          if (wd[0]) n_match = 0;
          if (wd[1]) n_ovf = 0;
        end
        4: begin
          m_presc = wd;
          n_pcnt  = 0;
        end
        default: ;
      endcase
    end
    m_en    = n_en;
    m_count = n_count;
    m_pcnt  = n_pcnt;
    m_match = n_match | set_m;
    m_ovf   = n_ovf | set_o;
  endtask

  // Present one bus cycle, queue its expected response, then step the model
  task automatic cycle(input bit r, input bit rw, input logic [31:0] a,
                       input logic [31:0] wd);
    exp_t e;
    rst     = r;
    s_rw    = rw;
    s_addr  = a;
    s_wdata = wd;
    e.addr  = a;
    e.rd    = model_read(r, a);
    e.irq   = m_irq;
    sbq.push_back(e);
    @(posedge clk);
    model_step(r, rw, a, wd);
    #1;
  endtask

  task automatic rd(input logic [7:0] off);
    cycle(0, 0, BASE + {24'h0, off}, 32'h0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] v);
    cycle(0, 1, BASE + {24'h0, off}, v);
  endtask

  // Monitor: every cycle presents a read result and an interrupt level
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (s_rdata !== e.rd) begin
        errors++;
        $display("FAIL rdata addr=%h got=%h exp=%h t=%0t", e.addr, s_rdata, e.rd, $time);
      end
      checks++;
      if (irq_o !== e.irq) begin
        errors++;
        $display("FAIL irq addr=%h got=%b exp=%b t=%0t", e.addr, irq_o, e.irq, $time);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sel, idx;
    logic [31:0] a, v;
    logic [7:0]  off;

    // Unchecked power-on reset so DUT and model start from a known state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_step(1, 0, 32'h0, 32'h0);
    #1;

    // Reset readback, unmapped offset, out-of-region
    cycle(1, 0, BASE, 32'h0);
    rd(TMR_CTRL); rd(TMR_COUNT); rd(TMR_CMP); rd(TMR_STATUS); rd(TMR_PRESC);
    wr(8'h14, 32'h1234);
    rd(8'h14);
    cycle(0, 0, 32'h5000_0004, 32'h0);
    cycle(0, 1, 32'h3FFF_FF04, 32'hDEAD);
    rd(TMR_COUNT);

    // Basic count: PRESC=3, CMP=5, EN|IE; match 24 clocks after the EN edge
    wr(TMR_PRESC, 32'd3);
    wr(TMR_CMP, 32'd5);
    wr(TMR_CTRL, 32'h9);
    for (int i = 0; i < 30; i++) begin
      if (i[0]) rd(TMR_COUNT); else rd(TMR_STATUS);
    end

    // Auto-reload sequence 0,1,2,0,1,2
    cycle(1, 0, BASE, 32'h0);
    wr(TMR_CMP, 32'd2);
    wr(TMR_CTRL, 32'h3);
    repeat (8) rd(TMR_COUNT);

    // One-shot: EN clears at first match, COUNT stops at 3
    wr(TMR_CTRL, 32'h0);
    wr(TMR_COUNT, 32'h0);
    wr(TMR_CTRL, 32'h5);
    for (int i = 0; i < 10; i++) begin
      if (i[0]) rd(TMR_CTRL); else rd(TMR_COUNT);
    end

    // Overflow from 0xFFFF_FFFE
    wr(TMR_CTRL, 32'h0);
    wr(TMR_STATUS, 32'h3);
    wr(TMR_CMP, 32'h10);
    wr(TMR_COUNT, 32'hFFFF_FFFE);
    wr(TMR_CTRL, 32'h1);
    rd(TMR_COUNT); rd(TMR_COUNT); rd(TMR_STATUS); rd(TMR_COUNT);

    // COUNT write in a tick cycle wins
    wr(TMR_COUNT, 32'h50);
    rd(TMR_COUNT);

    // W1C colliding with a fresh match, then a quiet W1C
    wr(TMR_CTRL, 32'h0);
    wr(TMR_STATUS, 32'h3);
    wr(TMR_COUNT, 32'h0);
    wr(TMR_CMP, 32'd3);
    wr(TMR_CTRL, 32'hB);
    for (int i = 0; i < 20 && m_count != 32'd3; i++) rd(TMR_STATUS);
    rd(TMR_STATUS);
    for (int i = 0; i < 20 && m_count != 32'd3; i++) rd(TMR_STATUS);
    wr(TMR_STATUS, 32'h1);
    rd(TMR_STATUS);
    wr(TMR_CTRL, 32'h8);
    wr(TMR_STATUS, 32'h3);
    rd(TMR_STATUS); rd(TMR_STATUS); rd(TMR_STATUS);

    // Reset while running with the interrupt asserted
    wr(TMR_COUNT, 32'h0);
    wr(TMR_CMP, 32'd1);
    wr(TMR_CTRL, 32'hB);
    for (int i = 0; i < 20 && !m_irq; i++) rd(TMR_STATUS);
    cycle(1, 0, BASE + 32'h4, 32'h0);
    rd(TMR_CTRL); rd(TMR_COUNT); rd(TMR_CMP); rd(TMR_STATUS); rd(TMR_PRESC);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 99);
      idx = $urandom_range(0, 6);
      off = 8'(idx * 4);
      if (sel < 1) begin
        cycle(1, 0, BASE + {24'h0, off}, 32'h0);
      end else if (sel < 5) begin
        a = {8'h50, 24'($urandom())};
        cycle(0, 1'($urandom_range(0, 1)), a, $urandom());
      end else if (sel < 70) begin
        cycle(0, 0, BASE + {24'h0, off} + 32'($urandom_range(0, 3)), 32'h0);
      end else begin
        case (idx)
          0: v = {$urandom_range(0, 1) ? 28'($urandom()) : 28'h0,
                  4'($urandom_range(0, 15) | ($urandom_range(0, 3) != 0 ? 1 : 0))};
          1: v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(0, 12));
          2: v = 32'($urandom_range(0, 12));
          3: v = 32'($urandom_range(0, 3));
          4: v = 32'($urandom_range(0, 3));
          default: v = $urandom();
        endcase
        wr(off, v);
      end
    end

    cycle(0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL drain pending=%0d", sbq.size());
      $fatal(1, "scoreboard did not drain");
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_timer.md
# sb_timer

Memory-mapped timer/compare peripheral that sits directly downstream of the system bus as its slave. It decodes the bus slave-side access (`s_rw`, `s_addr`, `s_wdata`) and returns `s_rdata`. It provides a prescaled 32-bit up-counter, a compare match, overflow detection, one-shot/auto-reload modes and a level interrupt to the core.

## Interface
Parameters:
- `DW`, 32: data width; equals `DATA_WIDTH`.
- `AW`, 32: address width; equals `MEM_ADDR_WIDTH`.
- `BASE_ADDR`, 32'h4000_0000: region base; the block owns `BASE_ADDR` .. `BASE_ADDR+0xFF`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `s_rw`  in  1  1 = write, 0 = read.
- `s_addr`  in  AW  byte address from the bus.
- `s_wdata`  in  DW  write data; always a full word.
- `s_rdata`  out  DW  read data; combinational.
- `irq_o`  out  1  level interrupt, registered.

## Operation
Register map. Offsets are word aligned; `s_addr[1:0]` is ignored.
- 0x00 CTRL:
  - bit0 EN: counter enable.
  - bit1 AR: auto-reload; COUNT clears to 0 on match.
  - bit2 OS: one-shot; EN clears on match.
  - bit3 IE: interrupt enable.
  - Other bits read 0.
- 0x04 COUNT: read/write current count.
- 0x08 CMP: compare value.
- 0x0C STATUS:
  - bit0 MATCH, bit1 OVF.
  - Write-1-to-clear; writing 0 has no effect.
- 0x10 PRESC: prescale divisor minus 1. A tick occurs every PRESC+1 clocks.
- Other offsets inside the region read 0 and ignore writes.
- Addresses outside the region read 0 and ignore writes.

Hit and write rules:
- Hit = `s_addr[AW-1:8] == BASE_ADDR[AW-1:8]`.
- A write takes effect on the rising edge when `s_rw`=1 and the access is a hit.

Prescaler:
- 32-bit `pcnt` increments every clock while EN=1.
- When `pcnt == PRESC`: `pcnt` goes to 0 and `tick` pulses for 1 cycle.
- When EN=0: `pcnt` holds 0 and no ticks are produced.
- Any write to PRESC or CTRL clears `pcnt`.

Counter, on each tick:
- If COUNT == CMP:
  - Set MATCH.
  - If AR=1, COUNT goes to 0; otherwise COUNT+1.
  - If OS=1, clear EN.
- Else if COUNT == 0xFFFF_FFFF: COUNT wraps to 0 and OVF is set.
- Else: COUNT+1.

Interrupt:
- `irq_o` next = IE & (MATCH | OVF).

Simultaneous events:
- Bus write to COUNT in a tick cycle: the written value wins; no match/overflow evaluation that cycle.
- W1C to STATUS in the same cycle a flag is set: the set wins; the flag stays 1.
- Write to CTRL in the OS-clear cycle: the written value wins.
- Write to CMP in a tick cycle: the compare uses the old CMP.

## Timing
- Reset: CTRL=0, COUNT=0, CMP=0xFFFF_FFFF, STATUS=0, PRESC=0, `pcnt`=0, `irq_o`=0.
- `s_rdata` is 0 while `rst`=1.
- `rst` asserted mid-count clears everything on the next edge; no partial updates.
- Read latency is 0 cycles: `s_rdata` reflects the registers as of the last edge, in the same cycle as `s_addr`.
- Writes are visible to a read in the cycle after the write edge.
- With PRESC=0 and EN=1, COUNT advances every clock.
- The first tick comes PRESC+1 clocks after EN is set.
- MATCH sets on the edge of the matching tick.
- `irq_o` rises 1 cycle after MATCH/OVF (registered).
- `irq_o` falls 1 cycle after the W1C or IE clear.
- No wait states and no handshake: every bus access completes in one cycle.

## Structure
- Add to the shared defines file:
  - Register offsets: `TMR_CTRL`, `TMR_COUNT`, `TMR_CMP`, `TMR_STATUS`, `TMR_PRESC`.
  - CTRL/STATUS bit indices.
  - The `TMR_BASE` default.
- One sub-module, `timer_prescaler`: inputs `clk`, `rst`, `en`, `clr`, `presc`; output `tick`.
- Register file, compare logic and read mux stay in `sb_timer`.

## Test plan
- Reset/readback:
  - After `rst`, read 0x00..0x10 → 0, 0, 0xFFFF_FFFF, 0, 0.
  - Write 0x1234 to offset 0x14 → reads 0.
  - Read outside the region → 0.
- Basic count:
  - PRESC=3, CMP=5, CTRL=EN|IE.
  - MATCH sets 24 clocks after the EN write edge.
  - `irq_o` is 1 one cycle later.
  - COUNT then continues to 6.
- Auto-reload and one-shot:
  - CTRL=EN|AR, CMP=2, PRESC=0 → COUNT sequence 0,1,2,0,1,2.
  - CTRL=EN|OS → EN reads 0 after the first match and COUNT stops at 3.
- Overflow:
  - COUNT=0xFFFF_FFFE, CMP=0x10, PRESC=0, EN=1.
  - After 2 clocks COUNT=0 and OVF=1.
- Collisions:
  - Write COUNT=0x50 in a tick cycle → reads 0x50.
  - W1C of MATCH in the same cycle as a new match → MATCH stays 1.
  - W1C in a later quiet cycle → MATCH is 0 and `irq_o` falls 1 cycle later.
- Reset mid-operation:
  - Assert `rst` for 1 cycle while running with `irq_o`=1 → all registers return to reset values next cycle; `irq_o`=0.
